// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and widths for the instruction-memory arbiter.
//   state_e  : arbiter FSM state (IDLE, WAIT)
//   owner_e  : which requester owns the transaction in flight
//   STARVE_W : width of the starvation counter (covers STARVE_MAX up to 15)
//   TIMER_W  : width of the WAIT timer (covers TIMEOUT up to 255)
package imem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // Upper ends of the legal parameter ranges; counters are sized for these
  // so any legal parameter value fits without re-deriving widths per instance.
  localparam int unsigned STARVE_MAX_LIMIT = 15;
  localparam int unsigned TIMEOUT_LIMIT    = 255;

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX_LIMIT) + 1;
  localparam int unsigned TIMER_W  = $clog2(TIMEOUT_LIMIT) + 1;

  // Saturating increment used by the starvation counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between the fetch
// stage (read-only) and the program loader / debug port (read/write). One
// transaction is outstanding at a time. The loader has fixed priority, but
// after STARVE_MAX consecutive loader grants while fetch waits, fetch is
// forced through. Fetch responses are dropped when a flush is seen while the
// fetch is in flight. A transaction with no completion after TIMEOUT WAIT
// cycles is abandoned and err_timeout pulses.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   f_req_valid/f_req_ready/f_addr fetch request (ready is combinational)
//   f_flush                        pipeline flush / redirect
//   f_rsp_valid/f_rsp_instr/f_rsp_addr  fetch response (valid is a pulse)
//   l_req_valid/l_req_ready/l_we/l_addr/l_wdata  loader request
//   l_rsp_valid/l_rsp_rdata        loader response (rdata is 0 for writes)
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command (en is 1 cycle)
//   mem_rdata/mem_rvalid           memory completion
//   err_timeout                    one-cycle pulse on an abandoned transaction
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both 1. Ready is only ever 1 in IDLE, out of reset, for the single
// requester that wins arbitration in that cycle; the requester must hold
// valid and its payload stable until that edge. Response valids are one-cycle
// pulses with no backpressure; response data holds until the next response.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_req_valid,
  output logic        f_req_ready,
  input  logic [31:0] f_addr,
  input  logic        f_flush,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_instr,
  output logic [31:0] f_rsp_addr,
  input  logic        l_req_valid,
  output logic        l_req_ready,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_rsp_valid,
  output logic [31:0] l_rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        err_timeout
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);
  localparam logic [TIMER_W-1:0]  TIMEOUT_C    = TIMER_W'(TIMEOUT);

  state_e              state_q,       state_d;
  owner_e              owner_q,       owner_d;
  logic                we_q,          we_d;
  logic                drop_q,        drop_d;
  logic [STARVE_W-1:0] starve_q,      starve_d;
  logic [TIMER_W-1:0]  timer_q,       timer_d;
  logic                mem_en_q,      mem_en_d;
  logic                mem_we_q,      mem_we_d;
  logic [31:0]         mem_addr_q,    mem_addr_d;
  logic [31:0]         mem_wdata_q,   mem_wdata_d;
  logic                f_rsp_valid_q, f_rsp_valid_d;
  logic [31:0]         f_rsp_instr_q, f_rsp_instr_d;
  logic [31:0]         f_rsp_addr_q,  f_rsp_addr_d;
  logic                l_rsp_valid_q, l_rsp_valid_d;
  logic [31:0]         l_rsp_rdata_q, l_rsp_rdata_d;
  logic                err_q,         err_d;

  logic f_elig;
  logic loader_pick;
  logic idle_ok;
  logic f_grant;
  logic l_grant;
  logic rsp_hit;
  logic timed_out;

  always_comb begin
    // Flush beats a fetch request in the same cycle.
    f_elig      = f_req_valid & ~f_flush;
    loader_pick = l_req_valid & (~f_elig | (starve_q < STARVE_MAX_C));
    // rstn gates the readies so nothing is granted while reset is held.
    idle_ok     = (state_q == IDLE) & rstn;
    l_grant     = idle_ok & loader_pick;
    f_grant     = idle_ok & f_elig & ~loader_pick;
    // Completion is ignored in the mem_en cycle itself; memory answers at
    // the earliest one cycle after the strobe.
    rsp_hit     = (state_q == WAIT) & ~mem_en_q & mem_rvalid;
    // A completion in the same cycle as the timeout takes precedence.
    timed_out   = (state_q == WAIT) & ~rsp_hit & (timer_q == TIMEOUT_C);
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    drop_d        = drop_q;
    starve_d      = starve_q;
    timer_d       = timer_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    f_rsp_valid_d = 1'b0;
    f_rsp_instr_d = f_rsp_instr_q;
    f_rsp_addr_d  = f_rsp_addr_q;
    l_rsp_valid_d = 1'b0;
    l_rsp_rdata_d = l_rsp_rdata_q;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (l_grant) begin
          state_d     = WAIT;
          owner_d     = OWN_LOADER;
          we_d        = l_we;
          drop_d      = 1'b0;
          timer_d     = TIMER_W'(1);
          mem_en_d    = 1'b1;
          mem_we_d    = l_we;
          mem_addr_d  = l_addr;
          mem_wdata_d = l_wdata;
          // Only loader wins that actually made fetch wait count as starvation.
          if (f_elig) begin
            starve_d = sat_inc(starve_q, STARVE_MAX_C);
          end
        end else if (f_grant) begin
          state_d     = WAIT;
          owner_d     = OWN_FETCH;
          we_d        = 1'b0;
          drop_d      = 1'b0;
          timer_d     = TIMER_W'(1);
          starve_d    = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
        end
      end

      WAIT: begin
        if ((owner_q == OWN_FETCH) && f_flush) begin
          drop_d = 1'b1;
        end
        if (rsp_hit) begin
          state_d = IDLE;
          timer_d = '0;
          drop_d  = 1'b0;
          if (owner_q == OWN_FETCH) begin
            // A flush in the completion cycle itself also kills the response.
            if (!(drop_q || f_flush)) begin
              f_rsp_valid_d = 1'b1;
              f_rsp_instr_d = mem_rdata;
              f_rsp_addr_d  = mem_addr_q;
            end
          end else begin
            l_rsp_valid_d = 1'b1;
            l_rsp_rdata_d = we_q ? 32'd0 : mem_rdata;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          timer_d = '0;
          drop_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      owner_q       <= OWN_FETCH;
      we_q          <= 1'b0;
      drop_q        <= 1'b0;
      starve_q      <= '0;
      timer_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      f_rsp_valid_q <= 1'b0;
      f_rsp_instr_q <= '0;
      f_rsp_addr_q  <= '0;
      l_rsp_valid_q <= 1'b0;
      l_rsp_rdata_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      drop_q        <= drop_d;
      starve_q      <= starve_d;
      timer_q       <= timer_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      f_rsp_instr_q <= f_rsp_instr_d;
      f_rsp_addr_q  <= f_rsp_addr_d;
      l_rsp_valid_q <= l_rsp_valid_d;
      l_rsp_rdata_q <= l_rsp_rdata_d;
      err_q         <= err_d;
    end
  end

  assign f_req_ready = f_grant;
  assign l_req_ready = l_grant;
  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_instr = f_rsp_instr_q;
  assign f_rsp_addr  = f_rsp_addr_q;
  assign l_rsp_valid = l_rsp_valid_q;
  assign l_rsp_rdata = l_rsp_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter (STARVE_MAX=4, TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled there, combinational readies 1 unit later.
module tb_imem_arbiter;

  logic        clk;
  logic        rstn;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_addr;
  logic        f_flush;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_instr;
  logic [31:0] f_rsp_addr;
  logic        l_req_valid;
  logic        l_req_ready;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_rsp_valid;
  logic [31:0] l_rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        err_timeout;

  int unsigned n_assert;
  int unsigned n_fail;
  logic        exp_l;

  imem_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .f_req_valid(f_req_valid),
    .f_req_ready(f_req_ready),
    .f_addr     (f_addr),
    .f_flush    (f_flush),
    .f_rsp_valid(f_rsp_valid),
    .f_rsp_instr(f_rsp_instr),
    .f_rsp_addr (f_rsp_addr),
    .l_req_valid(l_req_valid),
    .l_req_ready(l_req_ready),
    .l_we       (l_we),
    .l_addr     (l_addr),
    .l_wdata    (l_wdata),
    .l_rsp_valid(l_rsp_valid),
    .l_rsp_rdata(l_rsp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .err_timeout(err_timeout)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rstn        = 1'b0;
    f_req_valid = 1'b0;
    f_addr      = '0;
    f_flush     = 1'b0;
    l_req_valid = 1'b0;
    l_we        = 1'b0;
    l_addr      = '0;
    l_wdata     = '0;
    mem_rdata   = '0;
    mem_rvalid  = 1'b0;
    exp_l       = 1'b0;

    // ---- reset state: readies held low even with requests pending
    tick();
    tick();
    f_req_valid = 1'b1;
    l_req_valid = 1'b1;
    #1;
    chk("rst_f_ready", f_req_ready, 0);
    chk("rst_l_ready", l_req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_f_rsp_valid", f_rsp_valid, 0);
    chk("rst_l_rsp_valid", l_rsp_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_mem_addr", mem_addr, 0);
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // ---- fetch only, memory answers two cycles after mem_en
    f_req_valid = 1'b1;
    f_addr      = 32'h10;
    #1;
    chk("f1_f_ready", f_req_ready, 1);
    chk("f1_l_ready", l_req_ready, 0);
    tick();                                 // WAIT cycle 1
    chk("f1_ready_in_wait", f_req_ready, 0);
    chk("f1_mem_en", mem_en, 1);
    chk("f1_mem_addr", mem_addr, 32'h10);
    chk("f1_mem_we", mem_we, 0);
    f_req_valid = 1'b0;
    tick();                                 // WAIT cycle 2
    chk("f1_mem_en_pulse", mem_en, 0);
    tick();                                 // WAIT cycle 3
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00500093;
    tick();
    mem_rvalid = 1'b0;
    chk("f1_rsp_valid", f_rsp_valid, 1);
    chk("f1_rsp_instr", f_rsp_instr, 32'h00500093);
    chk("f1_rsp_addr", f_rsp_addr, 32'h10);
    tick();
    chk("f1_rsp_pulse", f_rsp_valid, 0);
    chk("f1_rsp_hold", f_rsp_instr, 32'h00500093);

    // ---- flush in IDLE beats a fetch request
    f_req_valid = 1'b1;
    f_flush     = 1'b1;
    #1;
    chk("idle_flush_ready", f_req_ready, 0);
    f_req_valid = 1'b0;
    f_flush     = 1'b0;
    tick();

    // ---- contention: expected grant order L,L,L,L,F,L,L,L,L,F back to back
    for (int i = 0; i < 10; i++) begin
      f_req_valid = 1'b1;
      f_addr      = 32'h100 + 32'(4 * i);
      l_req_valid = 1'b1;
      l_we        = 1'b0;
      l_addr      = 32'h200 + 32'(4 * i);
      exp_l       = ((i % 5) != 4);
      #1;
      chk($sformatf("arb%0d_l_ready", i), l_req_ready, exp_l);
      chk($sformatf("arb%0d_f_ready", i), f_req_ready, !exp_l);
      tick();                               // WAIT cycle 1
      chk($sformatf("arb%0d_wait_ready", i), l_req_ready | f_req_ready, 0);
      chk($sformatf("arb%0d_mem_addr", i), mem_addr,
          exp_l ? 32'h200 + 32'(4 * i) : 32'h100 + 32'(4 * i));
      tick();                               // WAIT cycle 2
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA0 + 32'(i);
      tick();                               // IDLE with response pulse
      mem_rvalid = 1'b0;
      chk($sformatf("arb%0d_l_rsp_valid", i), l_rsp_valid, exp_l);
      chk($sformatf("arb%0d_f_rsp_valid", i), f_rsp_valid, !exp_l);
      chk($sformatf("arb%0d_rsp_data", i), exp_l ? l_rsp_rdata : f_rsp_instr, 32'hA0 + 32'(i));
    end
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    tick();

    // ---- flush during fetch WAIT drops the response
    f_req_valid = 1'b1;
    f_addr      = 32'h20;
    #1;
    chk("fl_ready", f_req_ready, 1);
    tick();                                 // WAIT 1
    f_req_valid = 1'b0;
    tick();                                 // WAIT 2
    f_flush = 1'b1;
    tick();                                 // WAIT 3
    f_flush    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("fl_dropped", f_rsp_valid, 0);
    f_req_valid = 1'b1;
    f_addr      = 32'h80;
    #1;
    chk("fl_back_idle", f_req_ready, 1);
    tick();
    f_req_valid = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000013;
    tick();
    mem_rvalid = 1'b0;
    chk("fl_next_valid", f_rsp_valid, 1);
    chk("fl_next_addr", f_rsp_addr, 32'h80);
    chk("fl_next_instr", f_rsp_instr, 32'h00000013);
    tick();

    // ---- loader write then read; flush during the write has no effect
    l_req_valid = 1'b1;
    l_we        = 1'b1;
    l_addr      = 32'h40;
    l_wdata     = 32'hDEADBEEF;
    #1;
    chk("wr_ready", l_req_ready, 1);
    tick();                                 // WAIT 1
    l_req_valid = 1'b0;
    f_flush     = 1'b1;
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();                                 // WAIT 2
    f_flush = 1'b0;
    chk("wr_we_pulse", mem_we, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("wr_ack_valid", l_rsp_valid, 1);
    chk("wr_ack_rdata", l_rsp_rdata, 0);
    l_req_valid = 1'b1;
    l_we        = 1'b0;
    #1;
    chk("rd_ready", l_req_ready, 1);
    tick();                                 // WAIT 1: early rvalid must be ignored
    l_req_valid = 1'b0;
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD00001;
    tick();                                 // WAIT 2
    chk("rd_early_ignored", l_rsp_valid, 0);
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rd_valid", l_rsp_valid, 1);
    chk("rd_rdata", l_rsp_rdata, 32'hDEADBEEF);
    tick();

    // ---- timeout: no completion for 8 WAIT cycles
    f_req_valid = 1'b1;
    f_addr      = 32'h30;
    #1;
    chk("to_ready", f_req_ready, 1);
    tick();                                 // WAIT 1
    f_req_valid = 1'b0;
    repeat (7) tick();                      // WAIT 8
    f_req_valid = 1'b1;
    #1;
    chk("to_still_wait", f_req_ready, 0);
    chk("to_no_err_yet", err_timeout, 0);
    f_req_valid = 1'b0;
    tick();
    chk("to_err", err_timeout, 1);
    chk("to_no_rsp", f_rsp_valid, 0);
    f_req_valid = 1'b1;
    #1;
    chk("to_idle", f_req_ready, 1);
    f_req_valid = 1'b0;
    tick();
    chk("to_err_pulse", err_timeout, 0);
    mem_rvalid = 1'b1;                      // late completion in IDLE
    mem_rdata  = 32'hBAD00002;
    tick();
    mem_rvalid = 1'b0;
    chk("to_late_f", f_rsp_valid, 0);
    chk("to_late_l", l_rsp_valid, 0);
    tick();

    // ---- completion on the timeout cycle wins
    f_req_valid = 1'b1;
    f_addr      = 32'h34;
    tick();                                 // WAIT 1
    f_req_valid = 1'b0;
    repeat (7) tick();                      // WAIT 8
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000099;
    tick();
    mem_rvalid = 1'b0;
    chk("tie_no_err", err_timeout, 0);
    chk("tie_valid", f_rsp_valid, 1);
    chk("tie_instr", f_rsp_instr, 32'h00000099);
    tick();

    // ---- async reset mid-WAIT
    f_req_valid = 1'b1;
    f_addr      = 32'h50;
    tick();                                 // WAIT 1
    f_req_valid = 1'b0;
    chk("ar_mem_en", mem_en, 1);
    rstn        = 1'b0;
    f_req_valid = 1'b1;
    #1;
    chk("ar_mem_en_clr", mem_en, 0);
    chk("ar_mem_addr_clr", mem_addr, 0);
    chk("ar_instr_clr", f_rsp_instr, 0);
    chk("ar_faddr_clr", f_rsp_addr, 0);
    chk("ar_ready_low", f_req_ready, 0);
    f_req_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    mem_rvalid = 1'b1;                      // stale completion in IDLE
    mem_rdata  = 32'hBAD00003;
    tick();
    mem_rvalid = 1'b0;
    chk("ar_stale_ignored", f_rsp_valid, 0);
    f_req_valid = 1'b1;
    f_addr      = 32'h60;
    #1;
    chk("ar_fresh_ready", f_req_ready, 1);
    tick();
    f_req_valid = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000077;
    tick();
    mem_rvalid = 1'b0;
    chk("ar_fresh_valid", f_rsp_valid, 1);
    chk("ar_fresh_addr", f_rsp_addr, 32'h60);
    chk("ar_fresh_instr", f_rsp_instr, 32'h00000077);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
